temporizador_regressivo_bcd: RTL and testbench
==============================================

TEMPORIZADOR_REGRESSIVO_BCD -- requirements
Module: temporizador_regressivo_bcd

Interface
REQ-001 SHALL have parameter: PRESCALE_DIV, default 1000, clock cycles per internal tick (used only when TEMPORIZADOR_PRESCALER_EN is defined; legal range 2..65535).
REQ-002 SHALL have port: clock  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: tick  input  1  one-cycle count-enable pulse (external time base).
REQ-005 SHALL have port: load  input  1  load preset digits.
REQ-006 SHALL have port: start  input  1  start or resume countdown.
REQ-007 SHALL have port: pause  input  1  suspend countdown.
REQ-008 SHALL have port: carga_dezenas  input  4  BCD tens preset.
REQ-009 SHALL have port: carga_unidades  input  4  BCD units preset.
REQ-010 SHALL have port: dezenas  output  4  current BCD tens.
REQ-011 SHALL have port: unidades  output  4  current BCD units.
REQ-012 SHALL have port: ativo  output  1  valve enable, high only in RUN.
REQ-013 SHALL have port: fim  output  1  one-cycle pulse on reaching 00.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSED, DONE; all outputs registered.
REQ-015 Priority per cycle SHALL be: reset > load > pause > start > tick.
REQ-016 load in any state SHALL capture presets next edge and force IDLE; fim=0.
REQ-017 Preset digit >9 SHALL be clamped to 9 on capture.
REQ-018 start in IDLE with value !=00 SHALL enter RUN next edge; start with value 00 SHALL be ignored.
REQ-019 In RUN, each tick SHALL decrement value by 1 at the same edge the tick is sampled (digits visible one cycle after tick asserted).
REQ-020 Units borrow: units 0 -> 9 and tens decremented; tens never wrap below 0.
REQ-021 Tick in RUN that makes value 00 SHALL move FSM to DONE and assert fim for exactly that next cycle.
REQ-022 pause in RUN SHALL enter PAUSED; value frozen; a simultaneous tick SHALL be discarded.
REQ-023 start in PAUSED SHALL return to RUN; tick in same cycle discarded.
REQ-024 tick in IDLE, PAUSED, DONE SHALL have no effect; start in DONE SHALL be ignored.
REQ-025 DONE SHALL hold 00, ativo=0 until load or reset.
REQ-026 ativo SHALL be 1 exactly while state is RUN.

Reset
REQ-027 reset SHALL set state IDLE, dezenas=0, unidades=0, ativo=0, fim=0, prescaler count=0, in any state including mid-RUN.
REQ-028 No output SHALL depend on reset combinationally.

Configuration
REQ-029 With TEMPORIZADOR_PRESCALER_EN defined: internal counter SHALL generate a one-cycle tick every PRESCALE_DIV clocks, counting only in RUN, cleared on entry to RUN, load, and reset; tick port SHALL be ignored.
REQ-030 Without TEMPORIZADOR_PRESCALER_EN: tick port SHALL be the sole time base; no prescaler logic synthesized.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding typedef (2-bit), the 4-bit BCD digit typedef, and constant BCD_MAX=9.
REQ-032 SHALL instantiate sub-module digito_bcd_regressivo twice (units, tens): load, enable, clamp, borrow-in/borrow-out, zero flag.
REQ-033 Tens digit enable SHALL be the units digit borrow-out.

Verification
REQ-034 Load 2/3, start, 3 ticks -> 20 after third; 1 more tick -> 19; ativo=1 throughout.
REQ-035 Load 0/2, start, 2 ticks -> 00, fim high exactly 1 cycle, ativo=0, state DONE; further ticks and start -> no change.
REQ-036 Load 1/0, start, pause with simultaneous tick -> holds 10; 5 ticks -> holds 10; start, 1 tick -> 09.
REQ-037 Load F/C -> dezenas=9, unidades=9; start with load 0/0 -> remains IDLE, ativo=0.
REQ-038 Running at 45, assert reset -> next cycle 00, IDLE, ativo=0, fim=0; load during RUN -> IDLE with new value.
REQ-039 With TEMPORIZADOR_PRESCALER_EN, PRESCALE_DIV=4, load 0/3, start -> 00 and fim 12 clocks after RUN entry; tick port toggling has no effect.

Source files
------------

// File: rtl/temporizador_regressivo_bcd_pkg.sv
// ---------------------------------------------------------------------------
// temporizador_regressivo_bcd_pkg
// Shared types and constants for the two-digit BCD countdown timer:
//   estado_t : 2-bit FSM state encoding (IDLE, RUN, PAUSED, DONE)
//   bcd_t    : one 4-bit BCD digit
//   BCD_MAX  : largest legal BCD digit (9)
//   clamp_bcd: saturates a raw preset nibble to a legal digit
// ---------------------------------------------------------------------------
package temporizador_regressivo_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } estado_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Non-BCD presets (A..F) are saturated to 9 instead of being rejected.
    function automatic bcd_t clamp_bcd(input logic [3:0] raw);
        return (raw > BCD_MAX) ? BCD_MAX : raw;
    endfunction

endpackage

// File: rtl/temporizador_regressivo_bcd_digito.sv
// ---------------------------------------------------------------------------
// digito_bcd_regressivo
// One BCD down-counting digit with synchronous load (clamped to 9).
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset (value -> 0)
//   i_load        : capture clamp_bcd(i_preset) on the next edge
//   i_preset      : raw preset nibble
//   i_en          : decrement enable (borrow-in from the lower digit)
//   o_valor       : current digit (registered)
//   o_borrow      : borrow-out, high when enabled while at 0
//   o_zero        : digit is 0
// Parameter WRAP: 1 -> 0 wraps to 9 (units); 0 -> digit saturates at 0 (tens).
// ---------------------------------------------------------------------------
module digito_bcd_regressivo
    import temporizador_regressivo_bcd_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [3:0] i_preset,
    input  logic       i_en,
    output logic [3:0] o_valor,
    output logic       o_borrow,
    output logic       o_zero
);

    bcd_t r_valor;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valor <= '0;
        end else if (i_load) begin
            r_valor <= clamp_bcd(i_preset);
        end else if (i_en) begin
            if (r_valor == '0) begin
                if (WRAP) r_valor <= BCD_MAX;
            end else begin
                r_valor <= r_valor - 4'd1;
            end
        end
    end

    assign o_valor  = r_valor;
    assign o_zero   = (r_valor == '0);
    assign o_borrow = i_en && (r_valor == '0);

endmodule

// File: rtl/temporizador_regressivo_bcd.sv
// ---------------------------------------------------------------------------
// temporizador_regressivo_bcd
// Two-digit BCD countdown timer driving a valve enable.
// Ports:
//   clock          : system clock, rising edge
//   reset          : synchronous active-high reset
//   tick           : one-cycle count-enable pulse (external time base)
//   load           : capture carga_dezenas/carga_unidades, force IDLE
//   start          : start from IDLE (value != 00) or resume from PAUSED
//   pause          : suspend countdown while in RUN
//   carga_dezenas  : tens preset (clamped to 9)
//   carga_unidades : units preset (clamped to 9)
//   dezenas        : current tens digit
//   unidades       : current units digit
//   ativo          : high exactly while in RUN
//   fim            : one-cycle pulse when the count reaches 00
// Per-cycle priority: reset > load > pause > start > tick.
// Optional feature: define TEMPORIZADOR_PRESCALER_EN to replace the tick
// port with an internal prescaler firing every PRESCALE_DIV clocks in RUN.
// ---------------------------------------------------------------------------
module temporizador_regressivo_bcd
    import temporizador_regressivo_bcd_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] carga_dezenas,
    input  logic [3:0] carga_unidades,
    output logic [3:0] dezenas,
    output logic [3:0] unidades,
    output logic       ativo,
    output logic       fim
);

    estado_t r_estado;
    logic    r_ativo;
    logic    r_fim;

    logic       w_tick;
    logic       w_dec;
    logic       w_entra_run;
    logic       w_zero;
    logic       w_um;
    logic       w_borrow_uni;
    logic       w_borrow_dez;
    logic       w_zero_uni;
    logic       w_zero_dez;
    logic [3:0] w_uni;
    logic [3:0] w_dez;

`ifdef TEMPORIZADOR_PRESCALER_EN
    logic [15:0] r_presc_cnt;

    // Tick on the last count of each period; the counter only advances in
    // RUN so a pause freezes the partial period.
    assign w_tick = (r_estado == RUN) && (r_presc_cnt == 16'(PRESCALE_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || load || w_entra_run) begin
            r_presc_cnt <= '0;
        end else if (r_estado == RUN) begin
            if (r_presc_cnt == 16'(PRESCALE_DIV - 1)) r_presc_cnt <= '0;
            else                                      r_presc_cnt <= r_presc_cnt + 16'd1;
        end
    end
`else
    assign w_tick = tick;
`endif

    assign w_zero = w_zero_dez && w_zero_uni;
    assign w_um   = w_zero_dez && (w_uni == 4'd1);

    // Higher-priority controls in the same cycle swallow the tick.
    assign w_dec = !reset && !load && !pause && (r_estado == RUN) && w_tick;

    assign w_entra_run = !reset && !load && !pause && start &&
                         (((r_estado == IDLE) && !w_zero) || (r_estado == PAUSED));

    digito_bcd_regressivo #(.WRAP(1'b1)) u_unidades (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_load   (load),
        .i_preset (carga_unidades),
        .i_en     (w_dec),
        .o_valor  (w_uni),
        .o_borrow (w_borrow_uni),
        .o_zero   (w_zero_uni)
    );

    // Tens only move on a units borrow and saturate at 0.
    digito_bcd_regressivo #(.WRAP(1'b0)) u_dezenas (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_load   (load),
        .i_preset (carga_dezenas),
        .i_en     (w_borrow_uni),
        .o_valor  (w_dez),
        .o_borrow (w_borrow_dez),
        .o_zero   (w_zero_dez)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= IDLE;
            r_ativo  <= 1'b0;
            r_fim    <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            if (load) begin
                r_estado <= IDLE;
                r_ativo  <= 1'b0;
            end else begin
                case (r_estado)
                    IDLE: begin
                        if (w_entra_run) begin
                            r_estado <= RUN;
                            r_ativo  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            r_estado <= PAUSED;
                            r_ativo  <= 1'b0;
                        end else if (w_dec && w_um) begin
                            r_estado <= DONE;
                            r_ativo  <= 1'b0;
                            r_fim    <= 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (w_entra_run) begin
                            r_estado <= RUN;
                            r_ativo  <= 1'b1;
                        end
                    end
                    default: begin
                        r_estado <= DONE;
                        r_ativo  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dezenas  = w_dez;
    assign unidades = w_uni;
    assign ativo    = r_ativo;
    assign fim      = r_fim;

endmodule

// File: tb/tb_temporizador_regressivo_bcd.sv
module tb_temporizador_regressivo_bcd;

    logic       clock = 1'b0;
    logic       reset, tick, load, start, pause;
    logic [3:0] carga_dezenas, carga_unidades;
    logic [3:0] dezenas, unidades;
    logic       ativo, fim;

    int n_cmp = 0;
    int n_err = 0;

    temporizador_regressivo_bcd #(.PRESCALE_DIV(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .tick           (tick),
        .load           (load),
        .start          (start),
        .pause          (pause),
        .carga_dezenas  (carga_dezenas),
        .carga_unidades (carga_unidades),
        .dezenas        (dezenas),
        .unidades       (unidades),
        .ativo          (ativo),
        .fim            (fim)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [3:0] d, input logic [3:0] u);
        load = 1'b1; carga_dezenas = d; carga_unidades = u;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc(); reset = 1'b0;
        n_cmp++;
        if ({dezenas, unidades, ativo, fim} !== 10'h000) begin
            n_err++;
            $display("FAIL reset: got %h%h ativo=%b fim=%b, want 00 0 0", dezenas, unidades, ativo, fim);
        end
    endtask

    task automatic test_countdown();
        logic [7:0] exp_v [4] = '{8'h22, 8'h21, 8'h20, 8'h19};
        do_load(4'd2, 4'd3);
        do_start();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h23 || ativo !== 1'b1) begin
            n_err++;
            $display("FAIL start_23: got %h%h ativo=%b, want 23 1", dezenas, unidades, ativo);
        end
        for (int i = 0; i < 4; i++) begin
            do_tick();
            n_cmp++;
            if ({dezenas, unidades} !== exp_v[i] || ativo !== 1'b1 || fim !== 1'b0) begin
                n_err++;
                $display("FAIL countdown[%0d]: got %h%h ativo=%b fim=%b, want %h 1 0",
                         i, dezenas, unidades, ativo, fim, exp_v[i]);
            end
        end
    endtask

    task automatic test_done();
        do_load(4'd0, 4'd2);
        do_start();
        do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h01 || fim !== 1'b0) begin
            n_err++;
            $display("FAIL done_01: got %h%h fim=%b, want 01 0", dezenas, unidades, fim);
        end
        do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h00 || fim !== 1'b1 || ativo !== 1'b0) begin
            n_err++;
            $display("FAIL done_00: got %h%h fim=%b ativo=%b, want 00 1 0", dezenas, unidades, fim, ativo);
        end
        cyc();
        n_cmp++;
        if (fim !== 1'b0) begin
            n_err++;
            $display("FAIL fim_width: got fim=%b, want 0", fim);
        end
        do_tick();
        do_start();
        do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h00 || ativo !== 1'b0 || fim !== 1'b0) begin
            n_err++;
            $display("FAIL done_hold: got %h%h ativo=%b fim=%b, want 00 0 0", dezenas, unidades, ativo, fim);
        end
    endtask

    task automatic test_pause();
        do_load(4'd1, 4'd0);
        do_start();
        pause = 1'b1; tick = 1'b1; cyc(); pause = 1'b0; tick = 1'b0;
        n_cmp++;
        if ({dezenas, unidades} !== 8'h10 || ativo !== 1'b0) begin
            n_err++;
            $display("FAIL pause_tick: got %h%h ativo=%b, want 10 0", dezenas, unidades, ativo);
        end
        for (int i = 0; i < 5; i++) do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h10 || ativo !== 1'b0) begin
            n_err++;
            $display("FAIL paused_hold: got %h%h ativo=%b, want 10 0", dezenas, unidades, ativo);
        end
        // resume with a simultaneous tick: the tick is dropped
        start = 1'b1; tick = 1'b1; cyc(); start = 1'b0; tick = 1'b0;
        n_cmp++;
        if ({dezenas, unidades} !== 8'h10 || ativo !== 1'b1) begin
            n_err++;
            $display("FAIL resume: got %h%h ativo=%b, want 10 1", dezenas, unidades, ativo);
        end
        do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h09 || ativo !== 1'b1) begin
            n_err++;
            $display("FAIL resume_tick: got %h%h ativo=%b, want 09 1", dezenas, unidades, ativo);
        end
    endtask

    task automatic test_clamp();
        do_load(4'hF, 4'hC);
        n_cmp++;
        if ({dezenas, unidades} !== 8'h99 || ativo !== 1'b0) begin
            n_err++;
            $display("FAIL clamp: got %h%h ativo=%b, want 99 0", dezenas, unidades, ativo);
        end
        do_load(4'd0, 4'd0);
        do_start();
        do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h00 || ativo !== 1'b0 || fim !== 1'b0) begin
            n_err++;
            $display("FAIL start_zero: got %h%h ativo=%b fim=%b, want 00 0 0", dezenas, unidades, ativo, fim);
        end
    endtask

    task automatic test_reset_midrun();
        do_load(4'd4, 4'd6);
        do_start();
        do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h45 || ativo !== 1'b1) begin
            n_err++;
            $display("FAIL run_45: got %h%h ativo=%b, want 45 1", dezenas, unidades, ativo);
        end
        reset = 1'b1; cyc(); reset = 1'b0;
        n_cmp++;
        if ({dezenas, unidades} !== 8'h00 || ativo !== 1'b0 || fim !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midrun: got %h%h ativo=%b fim=%b, want 00 0 0", dezenas, unidades, ativo, fim);
        end
        do_start();
        n_cmp++;
        if (ativo !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got ativo=%b, want 0", ativo);
        end
        do_load(4'd5, 4'd0);
        do_start();
        do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h49 || ativo !== 1'b1) begin
            n_err++;
            $display("FAIL run_49: got %h%h ativo=%b, want 49 1", dezenas, unidades, ativo);
        end
        // load wins over a simultaneous tick and drops back to IDLE
        tick = 1'b1;
        do_load(4'd7, 4'd7);
        tick = 1'b0;
        n_cmp++;
        if ({dezenas, unidades} !== 8'h77 || ativo !== 1'b0) begin
            n_err++;
            $display("FAIL load_run: got %h%h ativo=%b, want 77 0", dezenas, unidades, ativo);
        end
        do_tick();
        n_cmp++;
        if ({dezenas, unidades} !== 8'h77) begin
            n_err++;
            $display("FAIL idle_tick: got %h%h, want 77", dezenas, unidades);
        end
    endtask

    task automatic test_prescaler();
        do_load(4'd0, 4'd3);
        do_start();  // RUN entered at this edge
        for (int c = 1; c <= 12; c++) begin
            tick = ~tick;
            cyc();
            if (c == 4 || c == 8 || c == 11) begin
                n_cmp++;
                if ({dezenas, unidades} !== ((c == 4) ? 8'h02 : 8'h01) || fim !== 1'b0) begin
                    n_err++;
                    $display("FAIL presc_c%0d: got %h%h fim=%b", c, dezenas, unidades, fim);
                end
            end
            if (c == 12) begin
                n_cmp++;
                if ({dezenas, unidades} !== 8'h00 || fim !== 1'b1 || ativo !== 1'b0) begin
                    n_err++;
                    $display("FAIL presc_done: got %h%h fim=%b ativo=%b, want 00 1 0",
                             dezenas, unidades, fim, ativo);
                end
            end
        end
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        carga_dezenas = 4'd0; carga_unidades = 4'd0;
        #2;
        test_reset();
`ifdef TEMPORIZADOR_PRESCALER_EN
        test_clamp();
        test_prescaler();
`else
        test_countdown();
        test_done();
        test_pause();
        test_clamp();
        test_reset_midrun();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
